// File: rtl/ternary_neuron_seq.sv
// Time-multiplexes one external ternary synapse multiplier across N synapses and accumulates the signed products.
// Latency: start accepted at t, beats at t+1..t+N (one per x_valid), result valid at t+N+1; min period N+2.
// Backpressure: x_valid gaps stall the sequencer; y_valid holds y_out stable until y_ready.
module ternary_neuron_seq #(
    parameter int N     = 8,
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             cfg_valid,
    input  logic [1:0]       cfg_w,
    output logic             cfg_ready,
    input  logic             start,
    input  logic             x_in,
    input  logic             x_valid,
    output logic             x_ready,
    output logic             syn_x,
    output logic             syn_zero,
    output logic             syn_sign,
    input  logic [1:0]       syn_y,
    output logic [ACC_W-1:0] y_out,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             busy
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    generate
        if (N < 2 || N > 64) begin : g_bad_n
            $error("ternary_neuron_seq: N must be in 2..64");
        end
        if (ACC_W < $clog2(N + 1) + 1) begin : g_bad_acc_w
            $error("ternary_neuron_seq: ACC_W too narrow for N");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        w [N];
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     idx;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  sum;
    logic              loaded;
    logic              cfg_wr;
    logic              ptr_wrap;
    logic              start_ok;
    logic              beat;
    logic              last_beat;

    // A write shares the IDLE cycle with start; the write wins and start is dropped.
    assign cfg_wr    = (state == IDLE) && cfg_valid;
    assign ptr_wrap  = (ptr == PW'(N - 1));
    assign start_ok  = (state == IDLE) && start && loaded && !cfg_valid;
    assign beat      = (state == RUN) && x_valid;
    assign last_beat = beat && (idx == PW'(N - 1));

    // The multiplier sees the current synapse weight in every state; x only while running.
    assign syn_x    = (state == RUN) && x_in;
    assign syn_zero = w[idx][0];
    assign syn_sign = w[idx][1];

    // Product is a signed 2-bit value; sign-extend into the accumulator.
    assign sum = acc + {{(ACC_W-2){syn_y[1]}}, syn_y};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; clear overrides every transition.
    always_comb begin
        state_nxt = state;
        cfg_ready = 1'b0;
        x_ready   = 1'b0;
        y_valid   = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                cfg_ready = 1'b1;
                if (start_ok) state_nxt = RUN;
            end
            RUN: begin
                x_ready = 1'b1;
                busy    = 1'b1;
                if (last_beat) state_nxt = DONE;
            end
            DONE: begin
                y_valid = 1'b1;
                busy    = 1'b1;
                if (y_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (clear) state_nxt = IDLE;
    end

    // Weight file, pointers, accumulator and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                w[i] <= 2'b01;
            end
            ptr    <= '0;
            idx    <= '0;
            acc    <= '0;
            loaded <= 1'b0;
            y_out  <= '0;
        end else if (clear) begin
            // Weights stay in place but are unusable until a full reload sets loaded.
            ptr    <= '0;
            idx    <= '0;
            acc    <= '0;
            loaded <= 1'b0;
        end else begin
            if (cfg_wr) begin
                w[ptr] <= cfg_w;
                ptr    <= ptr_wrap ? '0 : ptr + PW'(1);
                if (ptr_wrap) loaded <= 1'b1;
            end
            if (start_ok) begin
                acc <= '0;
                idx <= '0;
            end
            if (beat) begin
                acc <= sum;
                idx <= last_beat ? '0 : idx + PW'(1);
                if (last_beat) y_out <= sum;
            end
        end
    end

endmodule

// File: tb/tb_ternary_neuron_seq.sv
module tb_ternary_neuron_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [1:0] cfg_w = 2'b00;
    logic       cfg_ready;
    logic       start = 1'b0;
    logic       x_in = 1'b0;
    logic       x_valid = 1'b0;
    logic       x_ready;
    logic       syn_x;
    logic       syn_zero;
    logic       syn_sign;
    logic [1:0] syn_y;
    logic [7:0] y_out;
    logic       y_valid;
    logic       y_ready = 1'b0;
    logic       busy;

    int checks = 0;
    int failures = 0;

    logic [1:0] wexp [8];

    ternary_neuron_seq #(.N(8), .ACC_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .cfg_valid(cfg_valid), .cfg_w(cfg_w), .cfg_ready(cfg_ready),
        .start(start), .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready),
        .syn_x(syn_x), .syn_zero(syn_zero), .syn_sign(syn_sign), .syn_y(syn_y),
        .y_out(y_out), .y_valid(y_valid), .y_ready(y_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // External ternary multiplier: weight (+1/-1/0) times binary activation.
    assign syn_y = syn_zero ? 2'b00 : (!syn_x ? 2'b00 : (syn_sign ? 2'b11 : 2'b01));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] ws [8]);
        for (int i = 0; i < 8; i++) begin
            cfg_valid = 1'b1;
            cfg_w     = ws[i];
            wexp[i]   = ws[i];
            tick();
        end
        cfg_valid = 1'b0;
    endtask

    // Start one inference; gaps[c]=1 withholds x_valid in run cycle c.
    task automatic infer(input string tag, input logic [7:0] xs, input logic [15:0] gaps,
                         input logic [7:0] exp, input int exp_lat);
        int b;
        int cyc;
        int lat;
        logic [1:0] wcur;
        b = 0;
        cyc = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        chk({tag, "_busy"}, busy, 1);
        while (!y_valid && cyc < 64) begin
            x_valid = !gaps[cyc % 16];
            x_in    = xs[b];
            #1;
            wcur = wexp[b];
            chk({tag, "_xrdy"}, {x_ready, cfg_ready}, 2'b10);
            chk({tag, "_synw"}, {syn_sign, syn_zero}, wcur);
            chk({tag, "_synx"}, syn_x, xs[b]);
            @(posedge clk);
            if (x_valid) b++;
            #1;
            cyc++;
            lat++;
        end
        x_valid = 1'b0;
        chk({tag, "_yvld"}, y_valid, 1);
        chk({tag, "_y"}, y_out, exp);
        chk({tag, "_beats"}, b, 8);
        if (exp_lat > 0) chk({tag, "_lat"}, lat, exp_lat);
    endtask

    task automatic drain(input string tag, input int hold, input logic [7:0] exp);
        y_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_hold"}, {y_valid, y_out}, {1'b1, exp});
        end
        y_ready = 1'b1;
        tick();
        y_ready = 1'b0;
        chk({tag, "_idle"}, {busy, y_valid, cfg_ready}, 3'b001);
    endtask

    task automatic partial_run(input int beats);
        start = 1'b1;
        tick();
        start = 1'b0;
        x_valid = 1'b1;
        x_in = 1'b1;
        for (int i = 0; i < beats; i++) tick();
        x_valid = 1'b0;
    endtask

    logic [1:0] w_pos [8];
    logic [1:0] w_mix [8];
    logic [1:0] w_neg [8];

    initial begin
        for (int i = 0; i < 8; i++) begin
            w_pos[i] = 2'b00;
            w_neg[i] = 2'b10;
            wexp[i]  = 2'b01;
        end
        // +1,-1,0,+1,-1,-1,0,+1
        w_mix[0] = 2'b00; w_mix[1] = 2'b10; w_mix[2] = 2'b01; w_mix[3] = 2'b00;
        w_mix[4] = 2'b10; w_mix[5] = 2'b10; w_mix[6] = 2'b01; w_mix[7] = 2'b00;

        // Reset state
        #12;
        chk("rst_in", {y_valid, y_out, x_ready, busy, cfg_ready, syn_x}, {1'b0, 8'h00, 4'b0010});
        rst_n = 1'b1;
        tick();
        chk("rst_out", {y_valid, y_out, x_ready, busy, cfg_ready}, {1'b0, 8'h00, 3'b001});
        chk("rst_w", {syn_sign, syn_zero}, 2'b01);

        // Start without weights is dropped
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("nostart", busy, 0);
        tick();
        chk("nostart2", busy, 0);

        // All +1, x all ones, back-to-back: +8, valid 9 cycles after start
        load(w_pos);
        infer("pos", 8'hFF, 16'h0000, 8'h08, 9);
        drain("pos", 0, 8'h08);

        // Mixed weights; x = 1,1,1,0,1,1,1,1 (index 0 in bit 0) -> -1
        load(w_mix);
        infer("mix", 8'b1111_0111, 16'h0000, 8'hFF, 9);
        drain("mix", 0, 8'hFF);

        // Same with x_valid bubbles: result unchanged, 5 gaps stretch latency to 14
        infer("gap", 8'b1111_0111, 16'b0000_0101_0010_0110, 8'hFF, 14);
        drain("gap", 5, 8'hFF);

        // All -1, x all ones: -8, twice without reload
        load(w_neg);
        infer("neg1", 8'hFF, 16'h0000, 8'hF8, 9);
        drain("neg1", 0, 8'hF8);
        infer("neg2", 8'hFF, 16'h0000, 8'hF8, 9);
        drain("neg2", 0, 8'hF8);

        // start together with a write: start dropped, w[0] becomes +1 -> -6
        start = 1'b1;
        cfg_valid = 1'b1;
        cfg_w = 2'b00;
        tick();
        start = 1'b0;
        cfg_valid = 1'b0;
        wexp[0] = 2'b00;
        chk("cfgstart", busy, 0);
        infer("wr", 8'hFF, 16'h0000, 8'hFA, 9);
        drain("wr", 0, 8'hFA);

        // Async reset after 3 beats
        rst_n = 1'b1;
        load(w_pos);
        partial_run(3);
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("arst", {y_valid, y_out, x_ready, busy, cfg_ready, syn_x}, {1'b0, 8'h00, 4'b0010});
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) wexp[i] = 2'b01;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("arst_nostart", busy, 0);
        load(w_mix);
        infer("arst_rl", 8'hFF, 16'h0000, 8'h00, 9);
        drain("arst_rl", 0, 8'h00);

        // Soft clear after 3 beats, asserted together with start and x_valid
        load(w_pos);
        partial_run(3);
        clear = 1'b1;
        start = 1'b1;
        x_valid = 1'b1;
        tick();
        clear = 1'b0;
        x_valid = 1'b0;
        chk("clr_idle", {busy, x_ready, cfg_ready}, 3'b001);
        tick();
        start = 1'b0;
        chk("clr_nostart", busy, 0);
        load(w_neg);
        infer("clr_rl", 8'b0000_1111, 16'h0000, 8'hFC, 9);
        drain("clr_rl", 0, 8'hFC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
